// File: rtl/frontend_rw_scheduler.sv
// Read/write request scheduler in front of a memory backend: separate read and
// write FIFOs, per-read write-age snapshots for RAW/WAR ordering, and a write-drain mode.
module frontend_rw_scheduler #(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 32,
  parameter int ID_W     = 4,
  parameter int RD_DEPTH = 8,
  parameter int WR_DEPTH = 16,
  parameter int HIGH_WM  = 12,
  parameter int LOW_WM   = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic                          i_req_op,
  input  logic [ADDR_W-1:0]             i_req_addr,
  input  logic [ID_W-1:0]               i_req_id,
  input  logic [DATA_W-1:0]             i_req_wdata,
  output logic                          o_cmd_valid,
  input  logic                          i_cmd_ready,
  output logic                          o_cmd_op,
  output logic [ADDR_W-1:0]             o_cmd_addr,
  output logic [ID_W-1:0]               o_cmd_id,
  output logic [DATA_W-1:0]             o_cmd_wdata,
  output logic [$clog2(RD_DEPTH+1)-1:0] o_rd_count,
  output logic [$clog2(WR_DEPTH+1)-1:0] o_wr_count,
  output logic                          o_drain
);

  if (!((LOW_WM < HIGH_WM) && (HIGH_WM <= WR_DEPTH))) begin : g_param_check
    $error("frontend_rw_scheduler: requires LOW_WM < HIGH_WM <= WR_DEPTH");
  end

  localparam int RC_W = $clog2(RD_DEPTH + 1);
  localparam int WC_W = $clog2(WR_DEPTH + 1);
  localparam int RP_W = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
  localparam int WP_W = (WR_DEPTH > 1) ? $clog2(WR_DEPTH) : 1;
  localparam logic [RC_W-1:0] RD_FULL_C = RC_W'(RD_DEPTH);
  localparam logic [WC_W-1:0] WR_FULL_C = WC_W'(WR_DEPTH);
  localparam logic [WC_W-1:0] HIGH_C    = WC_W'(HIGH_WM);
  localparam logic [WC_W-1:0] LOW_C     = WC_W'(LOW_WM);
  localparam logic [RP_W-1:0] RD_LAST_C = RP_W'(RD_DEPTH - 1);
  localparam logic [WP_W-1:0] WR_LAST_C = WP_W'(WR_DEPTH - 1);

  typedef enum logic {MODE_NORMAL = 1'b0, MODE_DRAIN = 1'b1} mode_e;

  mode_e             mode_q, mode_d;
  logic              lock_q, lock_d;
  logic              lock_op_q, lock_op_d;
  logic [RP_W-1:0]   rd_wptr_q, rd_wptr_d, rd_rptr_q, rd_rptr_d;
  logic [WP_W-1:0]   wr_wptr_q, wr_wptr_d, wr_rptr_q, wr_rptr_d;
  logic [RC_W-1:0]   rd_count_q, rd_count_d;
  logic [WC_W-1:0]   wr_count_q, wr_count_d;

  logic [ADDR_W-1:0] rq_addr_q [RD_DEPTH];
  logic [ID_W-1:0]   rq_id_q   [RD_DEPTH];
  logic [WC_W-1:0]   rq_snap_q [RD_DEPTH];
  logic [WC_W-1:0]   rq_snap_d [RD_DEPTH];
  logic [ADDR_W-1:0] wq_addr_q [WR_DEPTH];
  logic [ID_W-1:0]   wq_id_q   [WR_DEPTH];
  logic [DATA_W-1:0] wq_data_q [WR_DEPTH];

  logic rd_full, wr_full, rd_push, wr_push, rd_pop, wr_pop;
  logic raw, war, read_ok, write_ok, sel_valid, sel_op, fire;
  logic [WC_W-1:0] head_snap;
  int   age;

  // Requests: accepted on i_req_valid && o_req_ready. Commands: o_cmd_* are held
  // stable from the first cycle o_cmd_valid is high until i_cmd_ready completes it.
  assign rd_full     = (rd_count_q == RD_FULL_C);
  assign wr_full     = (wr_count_q == WR_FULL_C);
  assign o_req_ready = i_req_op ? !wr_full : !rd_full;
  assign rd_push     = i_req_valid && o_req_ready && !i_req_op;
  assign wr_push     = i_req_valid && o_req_ready && i_req_op;
  assign head_snap   = rq_snap_q[rd_rptr_q];

  // A read's snapshot counts the writes ahead of it, which are the oldest entries
  // of the write FIFO; a read with snapshot 0 is older than every pending write.
  always_comb begin
    raw = 1'b0;
    war = 1'b0;
    age = 0;
    for (int i = 0; i < WR_DEPTH; i++) begin
      age = i - int'(wr_rptr_q);
      if (age < 0) age = age + WR_DEPTH;
      if ((age < int'(head_snap)) && (wq_addr_q[i] == rq_addr_q[rd_rptr_q])) raw = 1'b1;
    end
    for (int i = 0; i < RD_DEPTH; i++) begin
      age = i - int'(rd_rptr_q);
      if (age < 0) age = age + RD_DEPTH;
      if ((age < int'(rd_count_q)) && (rq_snap_q[i] == '0) &&
          (rq_addr_q[i] == wq_addr_q[wr_rptr_q])) war = 1'b1;
    end
  end

  always_comb begin
    read_ok   = (rd_count_q != '0) && !raw;
    write_ok  = (wr_count_q != '0) && !war;
    sel_valid = 1'b0;
    sel_op    = 1'b0;
    if (lock_q) begin
      sel_valid = 1'b1;
      sel_op    = lock_op_q;
    end else if (mode_q == MODE_DRAIN) begin
      if (write_ok) begin
        sel_valid = 1'b1;
        sel_op    = 1'b1;
      end else if (read_ok) begin
        sel_valid = 1'b1;
      end
    end else begin
      if (read_ok) begin
        sel_valid = 1'b1;
      end else if (write_ok) begin
        sel_valid = 1'b1;
        sel_op    = 1'b1;
      end
    end
  end

  assign fire        = sel_valid && i_cmd_ready;
  assign rd_pop      = fire && !sel_op;
  assign wr_pop      = fire && sel_op;
  assign o_cmd_valid = sel_valid;

  always_comb begin
    o_cmd_op    = 1'b0;
    o_cmd_addr  = '0;
    o_cmd_id    = '0;
    o_cmd_wdata = '0;
    if (sel_valid) begin
      o_cmd_op = sel_op;
      if (sel_op) begin
        o_cmd_addr  = wq_addr_q[wr_rptr_q];
        o_cmd_id    = wq_id_q[wr_rptr_q];
        o_cmd_wdata = wq_data_q[wr_rptr_q];
      end else begin
        o_cmd_addr = rq_addr_q[rd_rptr_q];
        o_cmd_id   = rq_id_q[rd_rptr_q];
      end
    end
  end

  always_comb begin
    mode_d     = mode_q;
    lock_d     = sel_valid && !i_cmd_ready;
    lock_op_d  = sel_op;
    rd_wptr_d  = rd_wptr_q;
    rd_rptr_d  = rd_rptr_q;
    wr_wptr_d  = wr_wptr_q;
    wr_rptr_d  = wr_rptr_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if ((mode_q == MODE_NORMAL) && (wr_count_q >= HIGH_C)) mode_d = MODE_DRAIN;
    if ((mode_q == MODE_DRAIN) && (wr_count_q <= LOW_C))   mode_d = MODE_NORMAL;
    if (rd_push) rd_wptr_d = (rd_wptr_q == RD_LAST_C) ? '0 : rd_wptr_q + RP_W'(1);
    if (rd_pop)  rd_rptr_d = (rd_rptr_q == RD_LAST_C) ? '0 : rd_rptr_q + RP_W'(1);
    if (wr_push) wr_wptr_d = (wr_wptr_q == WR_LAST_C) ? '0 : wr_wptr_q + WP_W'(1);
    if (wr_pop)  wr_rptr_d = (wr_rptr_q == WR_LAST_C) ? '0 : wr_rptr_q + WP_W'(1);
    if (rd_push && !rd_pop) rd_count_d = rd_count_q + RC_W'(1);
    if (!rd_push && rd_pop) rd_count_d = rd_count_q - RC_W'(1);
    if (wr_push && !wr_pop) wr_count_d = wr_count_q + WC_W'(1);
    if (!wr_push && wr_pop) wr_count_d = wr_count_q - WC_W'(1);
    for (int i = 0; i < RD_DEPTH; i++) begin
      rq_snap_d[i] = rq_snap_q[i];
      if (wr_pop && (rq_snap_q[i] != '0)) rq_snap_d[i] = rq_snap_q[i] - WC_W'(1);
    end
    // The new read must not count a write that leaves on this same edge.
    if (rd_push) rq_snap_d[rd_wptr_q] = wr_count_q - WC_W'(wr_pop);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mode_q     <= MODE_NORMAL;
      lock_q     <= 1'b0;
      lock_op_q  <= 1'b0;
      rd_wptr_q  <= '0;
      rd_rptr_q  <= '0;
      wr_wptr_q  <= '0;
      wr_rptr_q  <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
      for (int i = 0; i < RD_DEPTH; i++) rq_snap_q[i] <= '0;
    end else begin
      mode_q     <= mode_d;
      lock_q     <= lock_d;
      lock_op_q  <= lock_op_d;
      rd_wptr_q  <= rd_wptr_d;
      rd_rptr_q  <= rd_rptr_d;
      wr_wptr_q  <= wr_wptr_d;
      wr_rptr_q  <= wr_rptr_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      for (int i = 0; i < RD_DEPTH; i++) rq_snap_q[i] <= rq_snap_d[i];
    end
  end

  // Payload storage needs no reset: entries are only read inside the occupied range.
  always_ff @(posedge i_clk) begin
    if (rd_push) begin
      rq_addr_q[rd_wptr_q] <= i_req_addr;
      rq_id_q[rd_wptr_q]   <= i_req_id;
    end
    if (wr_push) begin
      wq_addr_q[wr_wptr_q] <= i_req_addr;
      wq_id_q[wr_wptr_q]   <= i_req_id;
      wq_data_q[wr_wptr_q] <= i_req_wdata;
    end
  end

  assign o_rd_count = rd_count_q;
  assign o_wr_count = wr_count_q;
  assign o_drain    = (mode_q == MODE_DRAIN);

endmodule

// File: tb/tb_frontend_rw_scheduler.sv
// Bench for frontend_rw_scheduler: directed ordering/drain/reset scenarios plus
// random traffic, all compared cycle by cycle against a queue-based reference model.
module tb_frontend_rw_scheduler;
  localparam int ADDR_W = 24, DATA_W = 32, ID_W = 4;
  localparam int RD_DEPTH = 8, WR_DEPTH = 16, HIGH_WM = 12, LOW_WM = 4;

  logic              clk;
  logic              i_rst;
  logic              i_req_valid, i_req_op, i_cmd_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic [ID_W-1:0]   i_req_id;
  logic [DATA_W-1:0] i_req_wdata;
  logic              o_req_ready, o_cmd_valid, o_cmd_op, o_drain;
  logic [ADDR_W-1:0] o_cmd_addr;
  logic [ID_W-1:0]   o_cmd_id;
  logic [DATA_W-1:0] o_cmd_wdata;
  logic [3:0]        o_rd_count;
  logic [4:0]        o_wr_count;

  frontend_rw_scheduler #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .RD_DEPTH(RD_DEPTH),
    .WR_DEPTH(WR_DEPTH), .HIGH_WM(HIGH_WM), .LOW_WM(LOW_WM)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_op(i_req_op),
    .i_req_addr(i_req_addr), .i_req_id(i_req_id), .i_req_wdata(i_req_wdata),
    .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready), .o_cmd_op(o_cmd_op),
    .o_cmd_addr(o_cmd_addr), .o_cmd_id(o_cmd_id), .o_cmd_wdata(o_cmd_wdata),
    .o_rd_count(o_rd_count), .o_wr_count(o_wr_count), .o_drain(o_drain)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    int                snap;
  } ent_t;

  ent_t        rq[$];
  ent_t        wq[$];
  bit          m_drain, m_lock, m_lock_op;
  bit          e_ready, e_valid, e_op, dut_acc;
  logic [63:0] e_cmd;
  logic [59:0] exp_rd_q[$];
  logic [59:0] exp_wr_q[$];
  logic [24:0] log_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    rq.delete();
    wq.delete();
    exp_rd_q.delete();
    exp_wr_q.delete();
    log_q.delete();
    m_drain   = 0;
    m_lock    = 0;
    m_lock_op = 0;
  endtask

  task automatic model_comb();
    bit raw, war, rok, wok;
    e_ready = i_req_op ? (wq.size() < WR_DEPTH) : (rq.size() < RD_DEPTH);
    raw = 0;
    war = 0;
    if (rq.size() > 0)
      for (int k = 0; k < rq[0].snap; k++)
        if (k < wq.size() && wq[k].addr == rq[0].addr) raw = 1;
    if (wq.size() > 0)
      foreach (rq[i]) if (rq[i].snap == 0 && rq[i].addr == wq[0].addr) war = 1;
    rok = (rq.size() > 0) && !raw;
    wok = (wq.size() > 0) && !war;
    e_valid = 0;
    e_op    = 0;
    if (m_lock) begin
      e_valid = 1; e_op = m_lock_op;
    end else if (m_drain) begin
      if (wok) begin e_valid = 1; e_op = 1; end
      else if (rok) e_valid = 1;
    end else begin
      if (rok) e_valid = 1;
      else if (wok) begin e_valid = 1; e_op = 1; end
    end
    e_cmd = '0;
    if (e_valid && e_op)  e_cmd = 64'({1'b1, 1'b1, wq[0].addr, wq[0].id, wq[0].data});
    if (e_valid && !e_op) e_cmd = 64'({1'b1, 1'b0, rq[0].addr, rq[0].id, 32'h0});
  endtask

  task automatic model_seq();
    bit   fire, acc;
    int   wc_pre;
    ent_t t;
    fire   = e_valid && i_cmd_ready;
    acc    = i_req_valid && e_ready;
    wc_pre = wq.size();
    if (!m_drain && wc_pre >= HIGH_WM) m_drain = 1;
    else if (m_drain && wc_pre <= LOW_WM) m_drain = 0;
    m_lock    = e_valid && !i_cmd_ready;
    m_lock_op = e_op;
    if (fire && e_op) begin
      t = wq.pop_front();
      foreach (rq[i]) begin
        t = rq[i];
        if (t.snap > 0) t.snap = t.snap - 1;
        rq[i] = t;
      end
    end else if (fire) begin
      t = rq.pop_front();
    end
    if (acc) begin
      t.addr = i_req_addr;
      t.id   = i_req_id;
      t.data = i_req_op ? i_req_wdata : '0;
      t.snap = i_req_op ? 0 : wc_pre - ((fire && e_op) ? 1 : 0);
      if (i_req_op) begin
        wq.push_back(t);
        exp_wr_q.push_back({i_req_addr, i_req_id, i_req_wdata});
      end else begin
        rq.push_back(t);
        exp_rd_q.push_back({i_req_addr, i_req_id, 32'h0});
      end
    end
  endtask

  // one clock: check at negedge, advance model at posedge, return at posedge+1
  task automatic cycle();
    logic [59:0] got, exp;
    @(negedge clk);
    model_comb();
    check("req_ready", 64'(o_req_ready), 64'(e_ready));
    check("cmd", 64'({o_cmd_valid, o_cmd_op, o_cmd_addr, o_cmd_id, o_cmd_wdata}), e_cmd);
    check("status", 64'({o_rd_count, o_wr_count, o_drain}),
          64'({4'(rq.size()), 5'(wq.size()), m_drain}));
    dut_acc = i_req_valid && o_req_ready;
    if (o_cmd_valid && i_cmd_ready) begin
      log_q.push_back({o_cmd_op, o_cmd_addr});
      got = {o_cmd_addr, o_cmd_id, o_cmd_wdata};
      if (o_cmd_op) begin
        exp = (exp_wr_q.size() > 0) ? exp_wr_q.pop_front() : '1;
        check("wr_fifo_order", 64'(got), 64'(exp));
      end else begin
        exp = (exp_rd_q.size() > 0) ? exp_rd_q.pop_front() : '1;
        check("rd_fifo_order", 64'(got), 64'(exp));
      end
    end
    @(posedge clk);
    model_seq();
    #1;
  endtask

  // driver tasks
  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic send(input bit op, input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id,
                      input logic [DATA_W-1:0] d);
    int tries;
    i_req_valid = 1; i_req_op = op; i_req_addr = a; i_req_id = id; i_req_wdata = d;
    tries   = 0;
    dut_acc = 0;
    while (!dut_acc && tries < 64) begin
      cycle();
      tries++;
    end
    check("send_accept", 64'(dut_acc), 64'(1));
    i_req_valid = 0; i_req_op = 0; i_req_addr = '0; i_req_id = '0; i_req_wdata = '0;
  endtask

  task automatic do_reset();
    i_rst = 1;
    i_req_valid = 0; i_req_op = 0; i_req_addr = '0; i_req_id = '0; i_req_wdata = '0;
    i_cmd_ready = 0;
    #1;
    check("rst_cmd", 64'({o_cmd_valid, o_cmd_op, o_cmd_addr, o_cmd_id, o_cmd_wdata}), 64'(0));
    check("rst_status", 64'({o_rd_count, o_wr_count, o_drain}), 64'(0));
    check("rst_ready", 64'(o_req_ready), 64'(1));
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    i_rst = 0;
  endtask

  function automatic logic [24:0] log_at(input int i);
    if (i < log_q.size()) return log_q[i];
    return '1;
  endfunction

  initial begin
    int rdy_pct, wr_pct;
    i_rst = 1;
    do_reset();

    // write then read same address, backend always ready
    i_cmd_ready = 1;
    send(1, 24'h100, 4'h1, 32'hDEAD);
    send(0, 24'h100, 4'h2, 32'h0);
    idle(3);
    check("wr_rd_first", 64'(log_at(0)), 64'({1'b1, 24'h100}));
    check("wr_rd_second", 64'(log_at(1)), 64'({1'b0, 24'h100}));
    check("wr_rd_count", 64'(log_q.size()), 64'(2));

    // RAW: younger read to 0x100 must wait for the older write
    do_reset();
    send(0, 24'h500, 4'h3, 32'h0);
    send(1, 24'h100, 4'h4, 32'hDEAD);
    send(0, 24'h100, 4'h5, 32'h0);
    i_cmd_ready = 1;
    idle(5);
    check("raw_0", 64'(log_at(0)), 64'({1'b0, 24'h500}));
    check("raw_1", 64'(log_at(1)), 64'({1'b1, 24'h100}));
    check("raw_2", 64'(log_at(2)), 64'({1'b0, 24'h100}));

    // WAR in drain mode: older read to 0x200 goes before write to 0x200
    do_reset();
    send(0, 24'h900, 4'h1, 32'h0);
    send(0, 24'h200, 4'h2, 32'h0);
    send(1, 24'h200, 4'h3, 32'hBEEF);
    for (int i = 0; i < 11; i++) send(1, 24'h1000 + 24'(i), 4'(i), $urandom);
    idle(1);
    check("war_drain", 64'(o_drain), 64'(1));
    i_cmd_ready = 1;
    idle(20);
    check("war_0", 64'(log_at(0)), 64'({1'b0, 24'h900}));
    check("war_1", 64'(log_at(1)), 64'({1'b0, 24'h200}));
    check("war_2", 64'(log_at(2)), 64'({1'b1, 24'h200}));

    // drain watermarks: 12 writes enter drain, exit at LOW_WM
    do_reset();
    for (int i = 0; i < 12; i++) send(1, 24'h2000 + 24'(i), 4'(i), $urandom);
    idle(1);
    check("drain_on", 64'(o_drain), 64'(1));
    check("drain_cnt", 64'(o_wr_count), 64'(12));
    i_cmd_ready = 1;
    idle(16);
    check("drain_off", 64'(o_drain), 64'(0));
    check("drain_empty", 64'(o_wr_count), 64'(0));
    check("drain_last", 64'(log_at(11)), 64'({1'b1, 24'h200B}));

    // held command stays put while mode flips underneath it
    do_reset();
    send(0, 24'h300, 4'h5, 32'h0);
    idle(5);
    for (int i = 0; i < 12; i++) send(1, 24'h3000 + 24'(i), 4'(i), $urandom);
    idle(1);
    check("hold_cmd", 64'({o_cmd_valid, o_cmd_op, o_cmd_addr, o_cmd_id}),
          64'({1'b1, 1'b0, 24'h300, 4'h5}));
    check("hold_drain", 64'(o_drain), 64'(1));
    i_cmd_ready = 1;
    idle(16);
    check("hold_0", 64'(log_at(0)), 64'({1'b0, 24'h300}));
    check("hold_1", 64'(log_at(1)), 64'({1'b1, 24'h3000}));

    // full read queue, then mixed traffic across pointer wrap
    do_reset();
    for (int i = 0; i < 8; i++) send(0, 24'h400 + 24'(i), 4'(i), 32'h0);
    i_req_op = 0;
    #1;
    check("full_rd_ready", 64'(o_req_ready), 64'(0));
    i_req_op = 1;
    #1;
    check("full_wr_ready", 64'(o_req_ready), 64'(1));
    i_req_op = 0;
    i_cmd_ready = 1;
    for (int i = 0; i < 20; i++) send(1'($urandom_range(0, 1)), 24'h500 + 24'(i), 4'(i), $urandom);
    idle(40);
    check("wrap_first", 64'(log_at(0)), 64'({1'b0, 24'h400}));
    check("wrap_eighth", 64'(log_at(7)), 64'({1'b0, 24'h407}));
    check("wrap_total", 64'(log_q.size()), 64'(28));

    // reset with traffic queued
    do_reset();
    for (int i = 0; i < 3; i++) send(0, 24'h600 + 24'(i), 4'(i), 32'h0);
    for (int i = 0; i < 5; i++) send(1, 24'h700 + 24'(i), 4'(i), $urandom);
    do_reset();
    i_cmd_ready = 1;
    idle(5);
    check("no_stale", 64'(log_q.size()), 64'(0));

    // random traffic with narrow address space for frequent hazards
    for (int blk = 0; blk < 15; blk++) begin
      rdy_pct = $urandom_range(10, 95);
      wr_pct  = $urandom_range(20, 80);
      for (int c = 0; c < 200; c++) begin
        i_req_valid = ($urandom_range(0, 99) < 70);
        i_req_op    = ($urandom_range(0, 99) < wr_pct);
        i_req_addr  = 24'($urandom_range(0, 7));
        i_req_id    = 4'($urandom);
        i_req_wdata = $urandom;
        i_cmd_ready = ($urandom_range(0, 99) < rdy_pct);
        cycle();
      end
      if ($urandom_range(0, 2) == 0) do_reset();
    end
    i_req_valid = 0;
    i_cmd_ready = 1;
    idle(40);
    check("final_rd_empty", 64'(o_rd_count), 64'(0));
    check("final_wr_empty", 64'(o_wr_count), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
